// File: rtl/xalu_ise_arb.sv
// Two-requester arbiter and response buffer in front of one shared xalu_ise datapath.
// Grants one op per cycle and captures the result into a per-requester slot.
module xalu_ise_arb #(
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic             ise_clk,
    input  logic             ise_rst,
    input  logic             req0_val,
    output logic             req0_rdy,
    input  logic             req0_lock,
    input  logic [5:0]       req0_fn,
    input  logic [6:0]       req0_imm,
    input  logic [31:0]      req0_in1,
    input  logic [31:0]      req0_in2,
    input  logic             req1_val,
    output logic             req1_rdy,
    input  logic             req1_lock,
    input  logic [5:0]       req1_fn,
    input  logic [6:0]       req1_imm,
    input  logic [31:0]      req1_in1,
    input  logic [31:0]      req1_in2,
    output logic             rsp0_val,
    input  logic             rsp0_rdy,
    output logic [31:0]      rsp0_out,
    output logic             rsp0_err,
    output logic             rsp1_val,
    input  logic             rsp1_rdy,
    output logic [31:0]      rsp1_out,
    output logic             rsp1_err,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [5:0]       alu_fn,
    output logic [6:0]       alu_imm,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    output logic             alu_val,
    input  logic             alu_oval,
    input  logic [31:0]      alu_out
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        elig0;
    logic        elig1;
    logic        gnt0;
    logic        gnt1;
    logic        rr_gnt;
    logic        rr_ptr;
    logic        lock_vld;
    logic        lock_id;
    logic        lock_vld_n;
    logic        lock_id_n;
    logic [31:0] cap_out;

    // A full slot being drained this cycle can take a new op.
    assign elig0 = req0_val && (!rsp0_val || rsp0_rdy);
    assign elig1 = req1_val && (!rsp1_val || rsp1_rdy);

    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        rr_gnt = 1'b0;
        if (lock_vld && !lock_id && elig0) begin
            gnt0 = 1'b1;
        end else if (lock_vld && lock_id && elig1) begin
            gnt1 = 1'b1;
        end else if (PRIO_MODE == 1) begin
            gnt0 = elig0;
            gnt1 = !elig0 && elig1;
        end else if (elig0 && elig1) begin
            rr_gnt = 1'b1;
            gnt0   = !rr_ptr;
            gnt1   = rr_ptr;
        end else begin
            rr_gnt = elig0 || elig1;
            gnt0   = elig0;
            gnt1   = elig1;
        end
        if (!ise_rst) begin
            gnt0   = 1'b0;
            gnt1   = 1'b0;
            rr_gnt = 1'b0;
        end
    end

    assign req0_rdy = gnt0;
    assign req1_rdy = gnt1;
    assign alu_val  = gnt0 || gnt1;

    always_comb begin
        alu_fn  = '0;
        alu_imm = '0;
        alu_in1 = '0;
        alu_in2 = '0;
        if (gnt0) begin
            alu_fn  = req0_fn;
            alu_imm = req0_imm;
            alu_in1 = req0_in1;
            alu_in2 = req0_in2;
        end else if (gnt1) begin
            alu_fn  = req1_fn;
            alu_imm = req1_imm;
            alu_in1 = req1_in1;
            alu_in2 = req1_in2;
        end
    end

    // Owner keeps the lock while it still requests, even when its slot is full.
    always_comb begin
        lock_id_n  = lock_id;
        lock_vld_n = lock_vld && (lock_id ? req1_val : req0_val);
        if (gnt0) begin
            if (req0_lock) begin
                lock_vld_n = 1'b1;
                lock_id_n  = 1'b0;
            end else if (!lock_id) begin
                lock_vld_n = 1'b0;
            end
        end else if (gnt1) begin
            if (req1_lock) begin
                lock_vld_n = 1'b1;
                lock_id_n  = 1'b1;
            end else if (lock_id) begin
                lock_vld_n = 1'b0;
            end
        end
    end

    assign cap_out = alu_oval ? alu_out : 32'h0;

    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            rr_ptr   <= 1'b0;
            lock_vld <= 1'b0;
            lock_id  <= 1'b0;
            rsp0_val <= 1'b0;
            rsp0_out <= '0;
            rsp0_err <= 1'b0;
            rsp1_val <= 1'b0;
            rsp1_out <= '0;
            rsp1_err <= 1'b0;
            cnt0     <= '0;
            cnt1     <= '0;
        end else begin
            lock_vld <= lock_vld_n;
            lock_id  <= lock_id_n;
            if (PRIO_MODE == 0 && rr_gnt) begin
                rr_ptr <= gnt0;
            end
            if (gnt0) begin
                rsp0_val <= 1'b1;
                rsp0_out <= cap_out;
                rsp0_err <= !alu_oval;
                cnt0     <= cnt0 + CNT_ONE;
            end else if (rsp0_val && rsp0_rdy) begin
                rsp0_val <= 1'b0;
            end
            if (gnt1) begin
                rsp1_val <= 1'b1;
                rsp1_out <= cap_out;
                rsp1_err <= !alu_oval;
                cnt1     <= cnt1 + CNT_ONE;
            end else if (rsp1_val && rsp1_rdy) begin
                rsp1_val <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xalu_ise_arb.sv
// Directed bench for xalu_ise_arb with a small behavioural ALU.
// ALU: imm 0x20 -> in1-in2, imm 0x01 -> unsupported, else in1+in2.
module tb_xalu_ise_arb;

    logic        clk;
    logic        rst;
    logic        req0_val, req0_rdy, req0_lock;
    logic [5:0]  req0_fn;
    logic [6:0]  req0_imm;
    logic [31:0] req0_in1, req0_in2;
    logic        req1_val, req1_rdy, req1_lock;
    logic [5:0]  req1_fn;
    logic [6:0]  req1_imm;
    logic [31:0] req1_in1, req1_in2;
    logic        rsp0_val, rsp0_rdy, rsp0_err;
    logic [31:0] rsp0_out;
    logic        rsp1_val, rsp1_rdy, rsp1_err;
    logic [31:0] rsp1_out;
    logic [15:0] cnt0, cnt1;
    logic [5:0]  alu_fn;
    logic [6:0]  alu_imm;
    logic [31:0] alu_in1, alu_in2;
    logic        alu_val, alu_oval;
    logic [31:0] alu_out;

    int n_chk;
    int n_err;

    xalu_ise_arb #(.PRIO_MODE(0), .CNT_W(16)) dut (
        .ise_clk  (clk),
        .ise_rst  (rst),
        .req0_val (req0_val),
        .req0_rdy (req0_rdy),
        .req0_lock(req0_lock),
        .req0_fn  (req0_fn),
        .req0_imm (req0_imm),
        .req0_in1 (req0_in1),
        .req0_in2 (req0_in2),
        .req1_val (req1_val),
        .req1_rdy (req1_rdy),
        .req1_lock(req1_lock),
        .req1_fn  (req1_fn),
        .req1_imm (req1_imm),
        .req1_in1 (req1_in1),
        .req1_in2 (req1_in2),
        .rsp0_val (rsp0_val),
        .rsp0_rdy (rsp0_rdy),
        .rsp0_out (rsp0_out),
        .rsp0_err (rsp0_err),
        .rsp1_val (rsp1_val),
        .rsp1_rdy (rsp1_rdy),
        .rsp1_out (rsp1_out),
        .rsp1_err (rsp1_err),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .alu_fn   (alu_fn),
        .alu_imm  (alu_imm),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_val  (alu_val),
        .alu_oval (alu_oval),
        .alu_out  (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_oval = alu_val && (alu_imm != 7'h01);
        alu_out  = (alu_imm == 7'h20) ? alu_in1 - alu_in2
                                      : alu_in1 + alu_in2;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set0(input logic v, input logic lk, input logic [6:0] imm,
                        input logic [31:0] a, input logic [31:0] b);
        req0_val  = v;
        req0_lock = lk;
        req0_imm  = imm;
        req0_in1  = a;
        req0_in2  = b;
    endtask

    task automatic set1(input logic v, input logic lk, input logic [6:0] imm,
                        input logic [31:0] a, input logic [31:0] b);
        req1_val  = v;
        req1_lock = lk;
        req1_imm  = imm;
        req1_in1  = a;
        req1_in2  = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        rst      = 1'b0;
        req0_fn  = 6'b000001;
        req1_fn  = 6'b000001;
        rsp0_rdy = 1'b0;
        rsp1_rdy = 1'b0;
        set0(1'b1, 1'b0, 7'h0, 32'h0, 32'h0);
        set1(1'b0, 1'b0, 7'h0, 32'h0, 32'h0);

        // reset state, with a request pending
        #12;
        check("rst_rsp0_val", {31'b0, rsp0_val}, 32'd0);
        check("rst_rsp1_val", {31'b0, rsp1_val}, 32'd0);
        check("rst_cnt0", {16'b0, cnt0}, 32'd0);
        check("rst_cnt1", {16'b0, cnt1}, 32'd0);
        check("rst_rsp0_out", rsp0_out, 32'd0);
        check("rst_req0_rdy", {31'b0, req0_rdy}, 32'd0);
        check("rst_alu_val", {31'b0, alu_val}, 32'd0);
        req0_val = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // single op on req0
        @(negedge clk);
        set0(1'b1, 1'b0, 7'h20, 32'h12345678, 32'h5);
        rsp0_rdy = 1'b1;
        rsp1_rdy = 1'b1;
        #1;
        check("t1_req0_rdy", {31'b0, req0_rdy}, 32'd1);
        check("t1_req1_rdy", {31'b0, req1_rdy}, 32'd0);
        check("t1_alu_in1", alu_in1, 32'h12345678);
        check("t1_alu_imm", {25'b0, alu_imm}, 32'h20);
        @(posedge clk);
        #1;
        check("t1_rsp0_val", {31'b0, rsp0_val}, 32'd1);
        check("t1_rsp0_out", rsp0_out, 32'h12345673);
        check("t1_rsp0_err", {31'b0, rsp0_err}, 32'd0);
        check("t1_cnt0", {16'b0, cnt0}, 32'd1);
        @(negedge clk);
        req0_val = 1'b0;
        @(posedge clk);
        #1;
        check("t1_drain_val", {31'b0, rsp0_val}, 32'd0);
        check("t1_drain_hold", rsp0_out, 32'h12345673);

        // round-robin alternation from reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set0(1'b1, 1'b0, 7'h0, 32'h100 + i, 32'h0);
            set1(1'b1, 1'b0, 7'h0, 32'h100 + i, 32'h10);
            #1;
            check($sformatf("t2_r0_%0d", i), {31'b0, req0_rdy},
                  (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t2_r1_%0d", i), {31'b0, req1_rdy},
                  (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
        check("t2_cnt0", {16'b0, cnt0}, 32'd4);
        check("t2_cnt1", {16'b0, cnt1}, 32'd4);
        check("t2_rsp0_out", rsp0_out, 32'h106);
        check("t2_rsp1_out", rsp1_out, 32'h117);

        // req1 holds a lock for three ops while req0 waits
        @(negedge clk);
        req0_val = 1'b0;
        set1(1'b1, 1'b1, 7'h0, 32'h1, 32'h1);
        #1;
        check("t3_c1_r0", {31'b0, req0_rdy}, 32'd0);
        check("t3_c1_r1", {31'b0, req1_rdy}, 32'd1);
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            set0(1'b1, 1'b0, 7'h0, 32'h2, 32'h2);
            #1;
            check($sformatf("t3_c%0d_r0", i), {31'b0, req0_rdy}, 32'd0);
            check($sformatf("t3_c%0d_r1", i), {31'b0, req1_rdy}, 32'd1);
        end
        @(negedge clk);
        req1_val  = 1'b0;
        req1_lock = 1'b0;
        #1;
        check("t3_c4_r0", {31'b0, req0_rdy}, 32'd1);
        check("t3_c4_r1", {31'b0, req1_rdy}, 32'd0);
        @(posedge clk);
        #1;
        check("t3_cnt0", {16'b0, cnt0}, 32'd5);
        check("t3_cnt1", {16'b0, cnt1}, 32'd7);
        @(negedge clk);
        req0_val = 1'b0;

        // backpressure on rsp0, then drain plus new grant together
        do_reset();
        rsp0_rdy = 1'b0;
        rsp1_rdy = 1'b1;
        @(negedge clk);
        set0(1'b1, 1'b0, 7'h0, 32'd1, 32'd2);
        #1;
        check("t4_c1_r0", {31'b0, req0_rdy}, 32'd1);
        @(negedge clk);
        set0(1'b1, 1'b0, 7'h0, 32'd10, 32'd20);
        set1(1'b1, 1'b0, 7'h0, 32'd5, 32'd6);
        #1;
        check("t4_c2_r0", {31'b0, req0_rdy}, 32'd0);
        check("t4_c2_r1", {31'b0, req1_rdy}, 32'd1);
        check("t4_c2_val0", {31'b0, rsp0_val}, 32'd1);
        check("t4_c2_out0", rsp0_out, 32'd3);
        @(negedge clk);
        req1_val = 1'b0;
        rsp0_rdy = 1'b1;
        #1;
        check("t4_c3_r0", {31'b0, req0_rdy}, 32'd1);
        @(posedge clk);
        #1;
        check("t4_val0", {31'b0, rsp0_val}, 32'd1);
        check("t4_out0", rsp0_out, 32'd30);
        check("t4_cnt0", {16'b0, cnt0}, 32'd2);
        check("t4_out1", rsp1_out, 32'd11);
        @(negedge clk);
        req0_val = 1'b0;

        // unsupported encoding, then a supported one clears the error
        @(negedge clk);
        set1(1'b1, 1'b0, 7'h01, 32'd7, 32'd8);
        #1;
        check("t5_r1", {31'b0, req1_rdy}, 32'd1);
        check("t5_alu_in2", alu_in2, 32'd8);
        @(posedge clk);
        #1;
        check("t5_err", {31'b0, rsp1_err}, 32'd1);
        check("t5_out", rsp1_out, 32'd0);
        check("t5_val", {31'b0, rsp1_val}, 32'd1);
        check("t5_cnt1", {16'b0, cnt1}, 32'd2);
        @(negedge clk);
        set1(1'b1, 1'b0, 7'h0, 32'd7, 32'd8);
        @(posedge clk);
        #1;
        check("t5_err_clr", {31'b0, rsp1_err}, 32'd0);
        check("t5_out2", rsp1_out, 32'd15);
        check("t5_cnt1b", {16'b0, cnt1}, 32'd3);
        @(negedge clk);
        req1_val = 1'b0;

        // counter wrap, then async reset with both slots full
        do_reset();
        @(negedge clk);
        set0(1'b1, 1'b0, 7'h0, 32'd1, 32'd1);
        rsp0_rdy = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        check("t6_cnt_max", {16'b0, cnt0}, 32'hFFFF);
        @(posedge clk);
        #1;
        check("t6_cnt_wrap", {16'b0, cnt0}, 32'h0);
        @(negedge clk);
        rsp0_rdy = 1'b0;
        set1(1'b1, 1'b0, 7'h0, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        check("t6_full0", {31'b0, rsp0_val}, 32'd1);
        check("t6_full1", {31'b0, rsp1_val}, 32'd1);
        check("t6_cnt1", {16'b0, cnt1}, 32'd1);
        @(negedge clk);
        req1_val = 1'b0;
        rsp0_rdy = 1'b1;
        #1;
        check("t6_pre_r0", {31'b0, req0_rdy}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t6_rst_val0", {31'b0, rsp0_val}, 32'd0);
        check("t6_rst_val1", {31'b0, rsp1_val}, 32'd0);
        check("t6_rst_cnt0", {16'b0, cnt0}, 32'd0);
        check("t6_rst_cnt1", {16'b0, cnt1}, 32'd0);
        check("t6_rst_out1", rsp1_out, 32'd0);
        check("t6_rst_r0", {31'b0, req0_rdy}, 32'd0);
        check("t6_rst_alu", {31'b0, alu_val}, 32'd0);
        check("t6_rst_in1", alu_in1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
